// File: rtl/neopixel_pkg.sv
// Shared NeoPixel types: FSM states, colour order, latch length and scaling.
package neopixel_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_SEND,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_LATCH
  } state_e;

  localparam bit ORDER_GRB = 1'b1;
  localparam bit ORDER_RGB = 1'b0;

  function automatic int latch_cycles(int clk_hz, int latch_us);
    return clk_hz / 1_000_000 * latch_us;
  endfunction

  // gain is brightness+1, so 256 leaves the colour untouched
  function automatic logic [7:0] scale8(logic [7:0] c, logic [8:0] gain);
    logic [15:0] p;
    p = 16'(c) * 16'(gain);
    return p[15:8];
  endfunction

endpackage

// File: rtl/neopixel_frame_feeder_if.sv
// Pixel handshake between the frame feeder and the serializer.
interface neopixel_frame_feeder_if;
  logic       pix_valid;
  logic [7:0] pix_r;
  logic [7:0] pix_g;
  logic [7:0] pix_b;
  logic       pix_busy;

  modport master (
    output pix_valid, pix_r, pix_g, pix_b,
    input  pix_busy
  );

  modport slave (
    input  pix_valid, pix_r, pix_g, pix_b,
    output pix_busy
  );
endinterface

// File: rtl/neopixel_pixel_ram.sv
// 1W/1R pixel RAM, synchronous read, read-before-write on address collision.
module neopixel_pixel_ram #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i && (int'(waddr_i) < DEPTH))
      mem_q[waddr_i] <= wdata_i;
    if (re_i)
      rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/neopixel_frame_feeder.sv
// Streams one frame of pixels to the NeoPixel serializer, then holds the latch gap.
// Optional brightness scaling: define NEOPIXEL_BRIGHTNESS_EN.
module neopixel_frame_feeder
  import neopixel_pkg::*;
#(
  parameter int NUM_PIXELS = 8,
  parameter int ADDR_W     = 3,
  parameter int CLK_HZ     = 12_000_000,
  parameter int LATCH_US   = 80,
  parameter bit GRB_ORDER  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  input  logic [7:0]        brightness,
  output logic              frame_busy,
  output logic              frame_done,
  neopixel_frame_feeder_if.master pix
);

  localparam int LATCH_CYC = latch_cycles(CLK_HZ, LATCH_US);
  localparam int CNT_W     = $clog2(LATCH_CYC + 1);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PIXELS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LATCH_CYC - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [23:0]       lanes_q, lanes_d;
  logic              rd_en;
  logic [23:0]       rd_data;
  logic [7:0]        c_r, c_g, c_b;

  neopixel_pixel_ram #(
    .DEPTH (NUM_PIXELS),
    .AW    (ADDR_W),
    .DW    (24)
  ) u_ram (
    .clk     (clk),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (rd_en),
    .raddr_i (idx_q),
    .rdata_o (rd_data)
  );

`ifdef NEOPIXEL_BRIGHTNESS_EN
  logic [8:0] gain;
  assign gain = {1'b0, brightness} + 9'd1;
  assign c_r  = scale8(rd_data[23:16], gain);
  assign c_g  = scale8(rd_data[15:8], gain);
  assign c_b  = scale8(rd_data[7:0], gain);
`else
  logic unused_bri;
  assign unused_bri = ^brightness;
  assign c_r = rd_data[23:16];
  assign c_g = rd_data[15:8];
  assign c_b = rd_data[7:0];
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    lanes_d = lanes_q;
    rd_en   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // the frame_done cycle still belongs to the old frame
        if (start && !done_q) begin
          state_d = S_FETCH;
          idx_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        rd_en   = 1'b1;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        if (GRB_ORDER == ORDER_GRB)
          lanes_d = {c_g, c_r, c_b};
        else
          lanes_d = {c_r, c_g, c_b};
        state_d = S_SEND;
      end
      S_SEND: state_d = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (pix.pix_busy)
          state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (!pix.pix_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_LATCH;
            cnt_d   = '0;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_FETCH;
          end
        end
      end
      S_LATCH: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      lanes_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      lanes_q <= lanes_d;
    end
  end

  assign frame_busy    = busy_q;
  assign frame_done    = done_q;
  assign pix.pix_valid = (state_q == S_SEND);
  assign pix.pix_r     = lanes_q[23:16];
  assign pix.pix_g     = lanes_q[15:8];
  assign pix.pix_b     = lanes_q[7:0];

endmodule

// File: tb/tb_neopixel_frame_feeder.sv
// Directed/random bench for neopixel_frame_feeder with a serializer model.
`timescale 1ns/1ps
module tb_neopixel_frame_feeder;

  localparam int N     = 8;
  localparam int LATCH = 960;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [23:0] wr_data = '0;
  logic        start = 1'b0;
  logic [7:0]  brightness = 8'd255;
  logic        frame_busy;
  logic        frame_done;

  neopixel_frame_feeder_if ifc();

  neopixel_frame_feeder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .brightness (brightness),
    .frame_busy (frame_busy),
    .frame_done (frame_done),
    .pix        (ifc)
  );

  always #5 clk = ~clk;

  // serializer: busy rises 5-40 cycles after valid, stays high 100-300
  int sdly = 0;
  int slen = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      sdly = 0;
      slen = 0;
      ifc.pix_busy = 1'b0;
    end else if (sdly > 0) begin
      sdly--;
      if (sdly == 0) begin
        ifc.pix_busy = 1'b1;
        slen = $urandom_range(300, 100);
      end
    end else if (slen > 0) begin
      slen--;
      if (slen == 0) ifc.pix_busy = 1'b0;
    end else if (ifc.pix_valid) begin
      sdly = $urandom_range(40, 5);
    end
  end

  logic [23:0] got[$];
  int          done_n = 0;
  always @(negedge clk) begin
    if (ifc.pix_valid) got.push_back({ifc.pix_r, ifc.pix_g, ifc.pix_b});
    if (frame_done) done_n++;
  end

  logic [23:0] mem [N];
  int tests = 0;
  int fails = 0;

  function automatic logic [23:0] exp_lanes(logic [23:0] c);
    int unsigned r, g, b;
    r = c[23:16];
    g = c[15:8];
    b = c[7:0];
`ifdef NEOPIXEL_BRIGHTNESS_EN
    r = (r * (brightness + 1)) / 256;
    g = (g * (brightness + 1)) / 256;
    b = (b * (brightness + 1)) / 256;
`endif
    return {8'(g), 8'(r), 8'(b)};
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(int a, logic [23:0] d);
    wr_en = 1'b1;
    wr_addr = 3'(a);
    wr_data = d;
    tick();
    wr_en = 1'b0;
    mem[a] = d;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_got(int n, string tag);
    int c = 0;
    while (got.size() < n && c < 6000) begin
      tick();
      c++;
    end
    chk(tag, 32'(got.size() >= n), 1);
  endtask

  task automatic wait_busy(logic lvl, string tag);
    int c = 0;
    while (ifc.pix_busy !== lvl && c < 1000) begin
      tick();
      c++;
    end
    chk(tag, 32'(ifc.pix_busy), 32'(lvl));
  endtask

  task automatic check_lanes(int base, string tag);
    for (int i = 0; i < N; i++)
      chk($sformatf("%s_px%0d", tag, i), 32'(got[base+i]), 32'(exp_lanes(mem[i])));
  endtask

  task automatic finish_frame(int base, int d0, string tag);
    int c = 0;
    wait_got(base + N, {tag, "_count"});
    while (done_n == d0 && c < 3000) begin
      tick();
      c++;
    end
    chk({tag, "_done"}, 32'(done_n - d0), 1);
    repeat (3) tick();
    chk({tag, "_nvalid"}, 32'(got.size() - base), N);
    check_lanes(base, tag);
  endtask

  int base, d0, lat, gap, prev_fb, pvbad, c;

  initial begin
    repeat (3) tick();
    chk("rst_fbusy", 32'(frame_busy), 0);
    chk("rst_fdone", 32'(frame_done), 0);
    chk("rst_valid", 32'(ifc.pix_valid), 0);
    chk("rst_lanes", 32'({ifc.pix_r, ifc.pix_g, ifc.pix_b}), 0);
    rst_n = 1'b1;
    tick();

    // frame 1: ramp pattern, latency and latch gap
    for (int i = 0; i < N; i++) wr(i, 24'(32'h010203 * i));
    base = got.size();
    d0 = done_n;
    pulse_start();
    chk("f1_fbusy", 32'(frame_busy), 1);
    lat = 1;
    while (!ifc.pix_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk("f1_latency", lat, 3);
    wait_got(base + N, "f1_count");
    wait_busy(1'b1, "f1_lastbusy_hi");
    wait_busy(1'b0, "f1_lastbusy_lo");
    gap = 0;
    pvbad = 0;
    prev_fb = 1;
    tick();
    while (!frame_done && gap < 2000) begin
      if (ifc.pix_valid) pvbad = 1;
      prev_fb = frame_busy;
      gap++;
      tick();
    end
    chk("f1_latch_gap", gap, LATCH);
    chk("f1_gap_valid", pvbad, 0);
    chk("f1_fbusy_before", prev_fb, 1);
    chk("f1_fbusy_fall", 32'(frame_busy), 0);
    tick();
    chk("f1_done_pulse", 32'(frame_done), 0);
    chk("f1_done_n", done_n - d0, 1);
    chk("f1_nvalid", got.size() - base, N);
    check_lanes(base, "f1");

    // frame 2: random data/brightness, ignored starts
    for (int i = 0; i < N; i++) wr(i, 24'($urandom));
    brightness = 8'($urandom);
    base = got.size();
    d0 = done_n;
    pulse_start();
    wait_got(base + 1, "f2_first");
    wait_busy(1'b1, "f2_busy0");
    pulse_start();
    c = 0;
    while (!frame_done && c < 6000) begin
      tick();
      c++;
    end
    chk("f2_done_seen", 32'(frame_done), 1);
    pulse_start();
    repeat (30) tick();
    chk("f2_no_restart", 32'(frame_busy), 0);
    chk("f2_nvalid", got.size() - base, N);
    chk("f2_done_n", done_n - d0, 1);
    check_lanes(base, "f2");

    // frame 3: the following start works; late write to pixel 7
    brightness = 8'd255;
    base = got.size();
    d0 = done_n;
    pulse_start();
    chk("f3_fbusy", 32'(frame_busy), 1);
    wait_got(base + 3, "f3_px2");
    wait_busy(1'b1, "f3_busy2");
    wr(7, 24'hFF0000);
    wr(5, 24'($urandom));
    finish_frame(base, d0, "f3");
    chk("f3_px7_g", 32'(got[base+7][15:8]), 32'h0000_00FF);

    // frame 4: reset during pixel 4 WAIT_ACK
    base = got.size();
    pulse_start();
    wait_got(base + 5, "f4_px4");
    tick();
    chk("f4_waitack", 32'(ifc.pix_busy), 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("f4_rst_fbusy", 32'(frame_busy), 0);
    chk("f4_rst_valid", 32'(ifc.pix_valid), 0);
    chk("f4_rst_lanes", 32'({ifc.pix_r, ifc.pix_g, ifc.pix_b}), 0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("f4_rst_nvalid", got.size() - base, 5);
    base = got.size();
    d0 = done_n;
    pulse_start();
    finish_frame(base, d0, "f4b");

    // frame 5: brightness 127 on 0xFF8001
    wr(0, 24'hFF8001);
    brightness = 8'd127;
    base = got.size();
    d0 = done_n;
    pulse_start();
    finish_frame(base, d0, "f5");
`ifdef NEOPIXEL_BRIGHTNESS_EN
    chk("f5_scaled", 32'(got[base]), 32'h0040_7F00);
`else
    chk("f5_unscaled", 32'(got[base]), 32'h0080_FF01);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
